// File: rtl/arb_2x1_rr_if.sv
// arb_2x1_rr_if: handshake bundle linking two sources, the round-robin arbiter and the downstream select stage.
// master = arbiter side, slave = environment (sources and downstream consumer).
interface arb_2x1_rr_if #(parameter int DATA_W = 8);
    logic              in0_valid;
    logic [DATA_W-1:0] in0_data;
    logic              in0_ready;
    logic              in1_valid;
    logic [DATA_W-1:0] in1_data;
    logic              in1_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              sel;
    logic              busy;
    modport master (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, sel, busy
    );
    modport slave (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, sel, busy
    );
endinterface

// File: rtl/arb_2x1_rr.sv
// arb_2x1_rr: two-channel round-robin arbiter with bounded bursts and a registered output beat.
// Define ARB_STATS_EN to add saturating per-channel accepted-beat counters (grant_cnt0/grant_cnt1).
module arb_2x1_rr #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    arb_2x1_rr_if.master bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t            state;
    logic              ptr;
    logic [7:0]        cnt;
    logic              own;
    logic              cur_valid;
    logic              oth_valid;
    logic              rdy;
    logic              acc;
    logic              rel;
    logic              win;
    logic [DATA_W-1:0] win_data;

    always_comb begin
        own       = (state == GRANT1);
        cur_valid = own ? bus.in1_valid : bus.in0_valid;
        oth_valid = own ? bus.in0_valid : bus.in1_valid;
        win_data  = own ? bus.in1_data : bus.in0_data;
        rdy       = (state != IDLE) && (!bus.out_valid || bus.out_ready);
        acc       = rdy && cur_valid;
        rel       = (state != IDLE) && ((acc && cnt == 8'(BURST_MAX - 1)) || !cur_valid);
        // on a tie the channel not named by the last-grant pointer wins
        win       = (bus.in0_valid && bus.in1_valid) ? !ptr : bus.in1_valid;
    end

    assign bus.in0_ready = rdy && !own;
    assign bus.in1_ready = rdy && own;
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= 1'b1;
            cnt           <= 8'd0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.sel       <= 1'b0;
        end else begin
            if (acc) begin
                bus.out_data  <= win_data;
                bus.sel       <= own;
                bus.out_valid <= 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (state == IDLE) begin
                cnt <= 8'd0;
                if (bus.in0_valid || bus.in1_valid) begin
                    state <= win ? GRANT1 : GRANT0;
                    ptr   <= win;
                end
            end else if (rel) begin
                cnt <= 8'd0;
                if (oth_valid) begin
                    state <= own ? GRANT0 : GRANT1;
                    ptr   <= !own;
                end else if (!cur_valid) begin
                    state <= IDLE;
                end
            end else if (acc) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else begin
            if (acc && !own && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (acc && own && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_arb_2x1_rr.sv
// tb_arb_2x1_rr: randomized and directed scoreboard bench for arb_2x1_rr against a behavioural arbitration model.
module tb_arb_2x1_rr;
    localparam int DW = 8;
    localparam int BM = 4;

    typedef struct {
        bit         s;
        logic [7:0] d;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, ordy = 1'b1;
    logic [7:0] d0 = 8'd0, d1 = 8'd0;
    logic       a0, a1;
    bit         log_en = 1'b0;
    bit         seen[$];
    beat_t      q[$];
    int         n_chk = 0, n_fail = 0;

    // behavioural model: owner (-1 = nobody), beats taken in this burst, last winner, output slot
    int m_own = -1, m_cnt = 0, m_last = 1, m_c, m_o;
    bit m_ov = 1'b0, m_sel = 1'b0, m_cv, m_acc;
    int m_st0 = 0, m_st1 = 0;

    always #5 clk = ~clk;

    arb_2x1_rr_if #(.DATA_W(DW)) bus();
    assign bus.in0_valid = v0;
    assign bus.in0_data  = d0;
    assign bus.in1_valid = v1;
    assign bus.in1_data  = d1;
    assign bus.out_ready = ordy;

`ifdef ARB_STATS_EN
    logic [15:0] gc0, gc1;
    arb_2x1_rr #(.DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .reset(reset), .bus(bus), .grant_cnt0(gc0), .grant_cnt1(gc1));
`else
    arb_2x1_rr #(.DATA_W(DW), .BURST_MAX(BM)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model advances on every rising edge using the values the bench drove
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_own = -1; m_cnt = 0; m_last = 1; m_ov = 0; m_sel = 0; m_st0 = 0; m_st1 = 0;
            q.delete();
        end else if (m_own < 0) begin
            if (m_ov && ordy) m_ov = 0;
            if (v0 || v1) begin
                m_own  = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
                m_last = m_own;
                m_cnt  = 0;
            end
        end else begin
            m_c   = m_own;
            m_cv  = m_c[0] ? v1 : v0;
            m_acc = m_cv && (!m_ov || ordy);
            if (m_acc) begin
                q.push_back(beat_t'{s: m_c[0], d: (m_c[0] ? d1 : d0)});
                m_cnt++;
                m_sel = m_c[0];
                m_ov  = 1;
                if (m_c[0]) m_st1 = (m_st1 < 65535) ? m_st1 + 1 : m_st1;
                else        m_st0 = (m_st0 < 65535) ? m_st0 + 1 : m_st0;
            end else if (m_ov && ordy) begin
                m_ov = 0;
            end
            if ((m_acc && m_cnt == BM) || !m_cv) begin
                m_cnt = 0;
                m_o   = 1 - m_c;
                if (m_o[0] ? v1 : v0) begin
                    m_own  = m_o;
                    m_last = m_o;
                end else if (!m_cv) begin
                    m_own = -1;
                end
            end
        end
    end

    // monitor: compares handshake outputs every cycle and pops the scoreboard when a beat is consumed
    initial forever begin
        @(negedge clk);
        chk("in0_ready", bus.in0_ready, (m_own == 0) && (!m_ov || ordy));
        chk("in1_ready", bus.in1_ready, (m_own == 1) && (!m_ov || ordy));
        chk("out_valid", bus.out_valid, m_ov);
        chk("busy", bus.busy, m_own >= 0);
        chk("sel", bus.sel, m_sel);
`ifdef ARB_STATS_EN
        chk("grant_cnt0", gc0, m_st0);
        chk("grant_cnt1", gc1, m_st1);
`endif
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard: beat %0h presented with no expected beat queued", bus.out_data);
            end else begin
                chk("out_data", bus.out_data, q[0].d);
                chk("beat_sel", bus.sel, q[0].s);
                if (ordy) begin
                    if (log_en) seen.push_back(q[0].s);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1; v0 = 0; v1 = 0; ordy = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    // sources hold valid until accepted, then present a fresh beat with probability p
    task automatic step(input int p0, input int p1, input int pr);
        @(negedge clk);
        a0 = v0 && bus.in0_ready;
        a1 = v1 && bus.in1_ready;
        @(posedge clk); #1;
        if (!v0 || a0) begin v0 = ($urandom_range(99) < p0); d0 = 8'($urandom); end
        if (!v1 || a1) begin v1 = ($urandom_range(99) < p1); d1 = 8'($urandom); end
        ordy = ($urandom_range(99) < pr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_out_data", bus.out_data, 0);

        // single beat from ch0: accepted on the 2nd edge, visible after it
        @(posedge clk); #1 v0 = 1; d0 = 8'hA1; ordy = 1;
        @(negedge clk); chk("t1_ready_c0", bus.in0_ready, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("t1_ready_c1", bus.in0_ready, 1);
        @(posedge clk); #1 v0 = 0;
        @(negedge clk);
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_data", bus.out_data, 8'hA1);
        chk("t1_sel", bus.sel, 0);
        chk("t1_in1_ready", bus.in1_ready, 0);

        // both channels saturated: bursts of BM alternate starting with ch0
        do_reset();
        seen.delete(); log_en = 1;
        repeat (40) step(100, 100, 100);
        log_en = 0;
        chk("burst_count_ok", seen.size() >= 35, 1);
        for (int i = 0; i < 16 && i < seen.size(); i++) chk("burst_sel", seen[i], (i / BM) % 2);

        // ch1 alone: re-granted back-to-back, sel pinned at 1
        do_reset();
        seen.delete(); log_en = 1;
        repeat (30) step(0, 100, 100);
        log_en = 0;
        chk("ch1_count_ok", seen.size() >= 25, 1);
        for (int i = 0; i < seen.size(); i++) chk("ch1_sel", seen[i], 1);

        // stall with 8'h3C held for 5 cycles
        do_reset();
        v0 = 1; d0 = 8'h3C; ordy = 0;
        @(posedge clk); #1;
        @(posedge clk); #1 d0 = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", bus.out_data, 8'h3C);
            chk("stall_sel", bus.sel, 0);
            chk("stall_ready", bus.in0_ready, 0);
            @(posedge clk); #1;
        end
        ordy = 1;
        @(posedge clk); #1 v0 = 0;
        @(negedge clk); chk("stall_next", bus.out_data, 8'h55);

        // reset after two beats of a ch0 burst
        do_reset();
        v0 = 1; v1 = 1; d0 = 8'h11; d1 = 8'h22; ordy = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_sel", bus.sel, 0);
        chk("mid_rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_tie_c0", bus.in0_ready, 1);
        chk("mid_rst_tie_c1", bus.in1_ready, 0);
        @(posedge clk); #1 v0 = 0; v1 = 0;

        // randomized traffic
        do_reset();
        repeat (300) step(70, 50, 60);
        repeat (300) step(30, 90, 90);
        do_reset();
        repeat (200) step(100, 100, 30);
        repeat (20) step(0, 0, 100);
        chk("sb_drained", q.size(), 0);

`ifdef ARB_STATS_EN
        begin
            int n;
            logic hs;
            do_reset();
            n = 0; v0 = 1; d0 = 8'($urandom);
            for (int k = 0; k < 100 && n < 10; k++) begin
                @(negedge clk); hs = v0 && bus.in0_ready; if (hs) n++;
                @(posedge clk); #1 if (hs) d0 = 8'($urandom); if (n == 10) v0 = 0;
            end
            n = 0; v1 = 1; d1 = 8'($urandom);
            for (int k = 0; k < 100 && n < 7; k++) begin
                @(negedge clk); hs = v1 && bus.in1_ready; if (hs) n++;
                @(posedge clk); #1 if (hs) d1 = 8'($urandom); if (n == 7) v1 = 0;
            end
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("stats_cnt0", gc0, 10);
            chk("stats_cnt1", gc1, 7);
            do_reset();
            @(negedge clk);
            chk("stats_rst0", gc0, 0);
            chk("stats_rst1", gc1, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
